// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned CLKS_PER_BIT = 868;  // 100 MHz system clock, 115200 baud

    typedef enum logic [1:0] {
        ARB,
        START,
        WAIT_HI,
        WAIT_LO
    } tx_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int unsigned IDX_W = $clog2(N);

    always_comb begin
        int unsigned j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!any && req[IDX_W'(j)]) begin
                grant[IDX_W'(j)] = 1'b1;
                idx              = IDX_W'(j);
                any              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Drives the TX start/busy handshake and flags a start that never produced busy.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [BYTE_W-1:0]          tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       locked,
    output logic                       timeout_err
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned TMR_W = $clog2(BUSY_TIMEOUT + 1);

    tx_arb_state_t      state;
    tx_arb_state_t      state_next;
    logic [IDX_W-1:0]   rr_ptr;
    logic [TMR_W-1:0]   timer;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               busy_expired;
    logic               last_byte;

    // While a message is open only the owner may compete, even if it is idle.
    assign elig         = locked ? (req_valid & (NUM_REQ'(1) << grant_id)) : req_valid;
    assign busy_expired = (timer == TMR_W'(BUSY_TIMEOUT - 1));
    assign last_byte    = ~locked;

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req   (elig),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB:     if (pick_any) state_next = START;
            START:   state_next = WAIT_HI;
            WAIT_HI: begin
                if (tx_busy) begin
                    state_next = WAIT_LO;
                end else if (busy_expired) begin
                    state_next = ARB;
                end
            end
            WAIT_LO: if (!tx_busy) state_next = ARB;
            default: state_next = ARB;
        endcase
    end

    // Accept pulse is combinational so a byte is taken in the first ARB cycle it is offered.
    always_comb begin
        req_ready = '0;
        if (state == ARB) begin
            req_ready = pick_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            locked      <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr      <= '0;
            timer       <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ARB: begin
                    if (pick_any) begin
                        tx_start <= 1'b1;
                        tx_data  <= req_data[32'(pick_idx) * BYTE_W +: BYTE_W];
                        grant_id <= pick_idx;
                        locked   <= ~req_last[pick_idx];
                    end
                end
                START: timer <= '0;
                WAIT_HI: begin
                    if (!tx_busy) begin
                        if (busy_expired) begin
                            timeout_err <= 1'b1;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                end
                WAIT_LO: begin
                    // Priority only rotates once a whole message has gone out.
                    if (!tx_busy && last_byte) begin
                        rr_ptr <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
